// File: rtl/divctrl_pkg.sv
// Shared types and reset defaults for the divider-cascade run/stop controller.
// Optional irq output is enabled with DIVCTRL_IRQ_EN.
package divctrl_pkg;

    localparam int DEF_CW = 24;
    localparam int DEF_LIM0_RST = 1666;
    localparam int DEF_LIM1_RST = 5000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    function automatic logic is_counting(input state_t s);
        return (s == RUN) || (s == STOP);
    endfunction

endpackage

// File: rtl/divctrl_chan.sv
// One divider channel: counter, active/shadow limit, pending flag, toggle output.
// Shadow limit commits in idle or on this channel's terminal count.
module divctrl_chan
    import divctrl_pkg::*;
#(
    parameter int W = DEF_CW,
    parameter int LIM_RST = DEF_LIM0_RST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         idle,
    input  logic         advance,
    input  logic         idle_clear,
    input  logic         wr,
    input  logic [W-1:0] lim_in,
    output logic         tc,
    output logic         out,
    output logic         pend
);

    logic [W-1:0] cnt;
    logic [W-1:0] active;
    logic [W-1:0] shadow;
    logic [W-1:0] eff;
    logic         commit;

    // A programmed limit of zero behaves as one.
    assign eff    = (active == '0) ? W'(1) : active;
    assign tc     = (cnt >= eff - W'(1));
    assign commit = pend && (idle || (advance && tc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= W'(LIM_RST);
            active <= W'(LIM_RST);
            pend   <= 1'b0;
        end else if (wr) begin
            shadow <= lim_in;
            pend   <= 1'b1;
        end else if (commit) begin
            active <= shadow;
            pend   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (idle_clear) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (advance) begin
            if (tc) begin
                cnt <= '0;
                out <= ~out;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/divctrl_sched.sv
// Run/stop sequencer and limit-config port for the two-channel divider cascade.
// Define DIVCTRL_IRQ_EN to add the irq pulse output on each out1 rise.
module divctrl_sched
    import divctrl_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int LIM0_RST = DEF_LIM0_RST,
    parameter int LIM1_RST = DEF_LIM1_RST
) (
    input  logic          F1,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic          cfg_sel,
    input  logic [CW-1:0] cfg_lim,
    output logic          busy,
    output logic          tick0,
    output logic          out0,
    output logic          out1
`ifdef DIVCTRL_IRQ_EN
    ,
    output logic          irq
`endif
);

    state_t state;
    state_t nxt;
    logic   run;
    logic   idle;
    logic   clear;
    logic   pend0;
    logic   pend1;
    logic   tc0;
    logic   tc1;
    logic   adv1;
    logic   acc;
    logic   wr0;
    logic   wr1;

    assign cfg_ready = cfg_sel ? !pend1 : !pend0;
    assign acc       = cfg_valid && cfg_ready;
    assign wr0       = acc && !cfg_sel;
    assign wr1       = acc && cfg_sel;

    always_ff @(posedge F1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= (nxt != IDLE);
        end
    end

    // run is low on the STOP->IDLE edge so counters clear instead of stepping.
    always_comb begin
        nxt = IDLE;
        run = 1'b0;
        unique case (state)
            IDLE: nxt = en ? RUN : IDLE;
            RUN: begin
                run = 1'b1;
                nxt = en ? RUN : STOP;
            end
            STOP: begin
                run = 1'b1;
                nxt = STOP;
                if (en) begin
                    nxt = RUN;
                end else if (!out0 && !out1) begin
                    nxt = IDLE;
                    run = 1'b0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign idle  = (state == IDLE);
    assign clear = !run;
    assign adv1  = run && tc0 && !out0;

    divctrl_chan #(
        .W(CW),
        .LIM_RST(LIM0_RST)
    ) u_ch0 (
        .clk(F1),
        .rst_n(rst_n),
        .idle(idle),
        .advance(run),
        .idle_clear(clear),
        .wr(wr0),
        .lim_in(cfg_lim),
        .tc(tc0),
        .out(out0),
        .pend(pend0)
    );

    divctrl_chan #(
        .W(CW),
        .LIM_RST(LIM1_RST)
    ) u_ch1 (
        .clk(F1),
        .rst_n(rst_n),
        .idle(idle),
        .advance(adv1),
        .idle_clear(clear),
        .wr(wr1),
        .lim_in(cfg_lim),
        .tc(tc1),
        .out(out1),
        .pend(pend1)
    );

    always_ff @(posedge F1 or negedge rst_n) begin
        if (!rst_n) begin
            tick0 <= 1'b0;
        end else begin
            tick0 <= run && tc0;
        end
    end

`ifdef DIVCTRL_IRQ_EN
    always_ff @(posedge F1 or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= adv1 && tc1 && !out1;
        end
    end
`endif

endmodule

// File: tb/tb_divctrl_sched.sv
// Directed-vector bench for divctrl_sched: limits, run/stop, reload, reset.
// Build with DIVCTRL_IRQ_EN defined to also check the irq pulse.
module tb_divctrl_sched;

    logic        F1;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_sel;
    logic [23:0] cfg_lim;
    logic        busy;
    logic        tick0;
    logic        out0;
    logic        out1;
`ifdef DIVCTRL_IRQ_EN
    logic        irq;
`endif

    int nvec;
    int nerr;
    int vidx;
    logic prev_o1;

    typedef struct {
        logic        en;
        logic        val;
        logic        sel;
        logic [23:0] lim;
        logic        o0;
        logic        o1;
        logic        t;
        logic        b;
        logic        r;
    } vec_t;

    vec_t tv[$];

    divctrl_sched dut (
        .F1(F1),
        .rst_n(rst_n),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel),
        .cfg_lim(cfg_lim),
        .busy(busy),
        .tick0(tick0),
        .out0(out0),
        .out1(out1)
`ifdef DIVCTRL_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    initial F1 = 1'b0;
    always #5 F1 = ~F1;

    task automatic chk(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL v%0d %s: got %b want %b", vidx, nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic e, input logic v,
                       input logic s, input logic [23:0] l,
                       input logic o0, input logic o1, input logic t,
                       input logic b, input logic r);
        vec_t x;
        x.en = e; x.val = v; x.sel = s; x.lim = l;
        x.o0 = o0; x.o1 = o1; x.t = t; x.b = b; x.r = r;
        for (int i = 0; i < n; i++) tv.push_back(x);
    endtask

    task automatic step(input vec_t x);
        @(negedge F1);
        en = x.en;
        cfg_valid = x.val;
        cfg_sel = x.sel;
        cfg_lim = x.lim;
        @(posedge F1);
        #1;
        vidx++;
        chk("out0", out0, x.o0);
        chk("out1", out1, x.o1);
        chk("tick0", tick0, x.t);
        chk("busy", busy, x.b);
        chk("cfg_ready", cfg_ready, x.r);
`ifdef DIVCTRL_IRQ_EN
        chk("irq", irq, x.o1 & ~prev_o1);
`endif
        prev_o1 = x.o1;
    endtask

    task automatic hs(input logic e, input logic v, input logic s,
                      input logic [23:0] l, input logic o0, input logic o1,
                      input logic t, input logic b, input logic r);
        vec_t x;
        x.en = e; x.val = v; x.sel = s; x.lim = l;
        x.o0 = o0; x.o1 = o1; x.t = t; x.b = b; x.r = r;
        step(x);
    endtask

    initial begin
        int n;
        nvec = 0;
        nerr = 0;
        vidx = 0;
        prev_o1 = 1'b0;
        rst_n = 1'b0;
        en = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel = 1'b0;
        cfg_lim = '0;

        // load 3/2 in idle, run, reload lim0=5 mid period, then 0 and lim1=1
        add(1, 0,1,0,24'd3, 0,0,0,0,0);
        add(1, 0,1,1,24'd2, 0,0,0,0,0);
        add(1, 1,0,1,24'd0, 0,0,0,1,1);
        add(2, 1,0,0,24'd0, 0,0,0,1,1);
        add(1, 1,0,0,24'd0, 1,0,1,1,1);
        add(2, 1,0,0,24'd0, 1,0,0,1,1);
        add(1, 1,0,0,24'd0, 0,0,1,1,1);
        add(2, 1,0,0,24'd0, 0,0,0,1,1);
        add(1, 1,0,0,24'd0, 1,1,1,1,1);
        add(2, 1,0,0,24'd0, 1,1,0,1,1);
        add(1, 1,0,0,24'd0, 0,1,1,1,1);
        add(2, 1,0,0,24'd0, 0,1,0,1,1);
        add(1, 1,0,0,24'd0, 1,1,1,1,1);
        add(2, 1,0,0,24'd0, 1,1,0,1,1);
        add(1, 1,0,0,24'd0, 0,1,1,1,1);
        add(2, 1,0,0,24'd0, 0,1,0,1,1);
        add(1, 1,0,0,24'd0, 1,0,1,1,1);
        add(1, 1,1,0,24'd5, 1,0,0,1,0);
        add(1, 1,0,0,24'd0, 1,0,0,1,0);
        add(1, 1,0,0,24'd0, 0,0,1,1,1);
        add(4, 1,0,0,24'd0, 0,0,0,1,1);
        add(1, 1,1,0,24'd0, 1,0,1,1,0);
        add(4, 1,0,0,24'd0, 1,0,0,1,0);
        add(1, 1,0,0,24'd0, 0,0,1,1,1);
        add(1, 1,1,1,24'd1, 1,1,1,1,0);
        add(1, 1,0,1,24'd0, 0,1,1,1,0);
        add(1, 1,0,1,24'd0, 1,1,1,1,0);
        add(1, 1,0,1,24'd0, 0,1,1,1,0);
        add(1, 1,0,1,24'd0, 1,0,1,1,1);
        add(1, 1,0,1,24'd0, 0,0,1,1,1);
        add(1, 1,0,1,24'd0, 1,1,1,1,1);
        add(1, 1,0,1,24'd0, 0,1,1,1,1);
        add(1, 1,0,1,24'd0, 1,0,1,1,1);

        #12;
        chk("rst out0", out0, 1'b0);
        chk("rst out1", out1, 1'b0);
        chk("rst tick0", tick0, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst ready0", cfg_ready, 1'b1);
        cfg_sel = 1'b1;
        #1;
        chk("rst ready1", cfg_ready, 1'b1);
        cfg_sel = 1'b0;
        @(negedge F1);
        rst_n = 1'b1;

        foreach (tv[i]) step(tv[i]);

        // drop en while out1 high: STOP until both low, then IDLE
        hs(1,0,0,24'd0, 0,0,1,1,1);
        hs(1,0,0,24'd0, 1,1,1,1,1);
        hs(0,0,0,24'd0, 0,1,1,1,1);
        hs(0,0,0,24'd0, 1,0,1,1,1);
        hs(0,0,0,24'd0, 0,0,1,1,1);
        hs(0,0,0,24'd0, 0,0,0,0,1);
        hs(0,0,0,24'd0, 0,0,0,0,1);

        // re-raise en during STOP keeps the waveform going
        hs(0,1,0,24'd2, 0,0,0,0,0);
        hs(1,0,0,24'd0, 0,0,0,1,1);
        hs(1,0,0,24'd0, 0,0,0,1,1);
        hs(1,0,0,24'd0, 1,1,1,1,1);
        hs(0,0,0,24'd0, 1,1,0,1,1);
        hs(1,0,0,24'd0, 0,1,1,1,1);
        hs(1,0,0,24'd0, 0,1,0,1,1);
        hs(1,0,0,24'd0, 1,0,1,1,1);
        hs(1,1,0,24'd7, 1,0,0,1,0);

        // async reset mid-run drops a pending write and restores limits
        @(negedge F1);
        cfg_valid = 1'b0;
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        vidx++;
        chk("arst out0", out0, 1'b0);
        chk("arst out1", out1, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst tick0", tick0, 1'b0);
        chk("arst ready0", cfg_ready, 1'b1);
        @(negedge F1);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge F1);
            #1;
            n++;
            if (out0) break;
        end
        vidx++;
        chk("first toggle at 1667th edge", n == 1667, 1'b1);
        chk("tick0 with first toggle", tick0, 1'b1);
        chk("out1 after restart", out1, 1'b0);
        chk("ready after restart", cfg_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/divctrl_sched.md
# divctrl_sched

Run/stop sequencer and limit-configuration controller for the two-stage clock-divider cascade. Channel 0 divides the system clock. Channel 1 counts channel-0 rising edges, giving the same cascade as the existing divider chain. The block adds start/stop sequencing, glitch-free runtime limit reloads through a valid/ready port, and clean stop-at-low behaviour. All logic runs in one clock domain; outputs are registered square waves plus a one-cycle tick.

## Interface
- CW, 24, width of counters, limits and cfg_lim
- LIM0_RST, 1666, channel-0 half-period limit after reset
- LIM1_RST, 5000, channel-1 half-period limit after reset
- F1  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run request (level)
- cfg_valid  in  1  limit-write request
- cfg_ready  out  1  limit write can be accepted
- cfg_sel  in  1  target channel (0/1)
- cfg_lim  in  CW  new half-period limit
- busy  out  1  state != IDLE
- tick0  out  1  one-cycle pulse on every out0 toggle
- out0  out  1  channel-0 divided clock
- out1  out  1  channel-1 divided clock

## Operation
- Reset values:
  - State and outputs: IDLE; out0=out1=tick0=busy=0.
  - Counters and pending flags: cnt0=cnt1=0; pend0=pend1=0.
  - Limits: active and shadow limits = LIM*_RST.
- Effective limit: lim_eff = max(active, 1). A limit of 0 behaves as 1.
- Config port:
  - cfg_ready = !pend[cfg_sel] (combinational).
  - Accept on cfg_valid & cfg_ready: shadow[sel] ← cfg_lim and pend[sel] ← 1.
- Commit:
  - In IDLE, commit happens on the cycle after accept.
  - In RUN/STOP, commit happens on that channel's terminal count (TC), and the new limit governs the following half-period.
  - Commit clears pend.
- Channel 0, when counting (RUN/STOP):
  - TC0 = cnt0 >= lim0_eff-1.
  - On TC0: cnt0←0, out0 toggles, tick0←1.
  - Otherwise: cnt0++.
- Channel 1 advances only when TC0 & out0==0 (an out0 rising edge).
  - TC1 = cnt1 >= lim1_eff-1.
  - On TC1: cnt1←0, out1 toggles.
  - Otherwise: cnt1++.
- Output periods: out0 = 2·lim0_eff cycles; out1 = 4·lim0_eff·lim1_eff cycles.
- FSM:
  - IDLE: counters held at 0. en=1 → RUN.
  - RUN: counting. en=0 → STOP.
  - STOP: counting continues.
    - en=1 → RUN, with no counter or output disturbance.
    - Else, if out0==0 & out1==0 → IDLE, clearing cnt0 and cnt1 on that edge.
  - Encoding 3 is illegal and recovers to IDLE.
- Boundary cases:
  - An accept on the same cycle as that channel's TC does not commit on that TC; it commits at the next TC.
  - Accept for one channel while the other is pending is allowed.
  - Asynchronous reset mid-operation restores all reset values at once, and pending writes are lost.

## Timing
- IDLE→RUN:
  - en sampled at edge k gives state RUN after k.
  - First out0 toggle occurs at edge k+lim0_eff.
- tick0 is high for exactly the cycle following the edge on which out0 toggles; it is never high in IDLE.
- busy is registered and follows the state with 0 extra latency.
- cfg_ready falls the cycle after accept, and rises the cycle after commit.
- STOP→IDLE takes 1 cycle once both outputs are low. If both outputs are already low at the RUN→STOP edge, IDLE follows on the next edge.

## Configuration
- DIVCTRL_IRQ_EN defined:
  - Adds output irq (1 bit, reset 0).
  - irq is a registered one-cycle pulse, asserted in the same cycle out1 rises.
- DIVCTRL_IRQ_EN undefined: the irq port and its logic are absent; all other behaviour is identical.

## Structure
- Package divctrl_pkg:
  - state type IDLE=2'd0, RUN=2'd1, STOP=2'd2.
  - default CW and LIM constants.
- Sub-module divctrl_chan, instantiated twice:
  - Contents: counter, active/shadow limit, pend flag, toggle register.
  - Inputs: advance, idle_clear, write strobe.
  - Outputs: TC and out.
- The FSM and config decode live in the top level.

## Test plan
- Reset: hold rst_n=0 → out0=out1=tick0=busy=0, cfg_ready=1; with en=1, first out0 toggle 1666 cycles after release.
- Load lim0=3, lim1=2 in IDLE, then en=1 → out0 toggles every 3 cycles; out1 toggles every 12 cycles; tick0 pulses every 3 cycles.
- RUN with lim0=3, write lim0=5 mid half-period:
  - cfg_ready(sel=0) drops.
  - The current half-period stays 3, then half-periods become 5.
  - cfg_ready rises the cycle after the commit.
- Write lim0=0 → out0 toggles every cycle and tick0 is held high; write lim1=1 → out1 toggles on every out0 rise.
- Drop en while out1=1 → STOP, busy=1 until out0=out1=0, then IDLE with counters 0; a separate run re-raises en during STOP → RUN with an uninterrupted waveform.
- Assert rst_n low mid-RUN → out0/out1 go 0 asynchronously, pend is cleared, limits revert to 1666/5000; with DIVCTRL_IRQ_EN, irq pulses once per out1 rise.
